// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave memory: word-addressed RAM with byte strobes and
// independent single-outstanding write and read burst engines.
module ei_axi4_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int LNB = $clog2(NB);
    localparam int IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_t;
    typedef enum logic {R_IDLE, R_DATA} rst_t;

    function automatic logic f_wrap_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic f_cmd_err(input logic [1:0] burst, input logic [2:0] size);
        return (burst == 2'b11) || (size > 3'(LNB));
    endfunction

    // Full-width compare so high address bits never alias into the RAM.
    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> LNB) < ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    function automatic logic [IW-1:0] f_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] w;
        w = a >> LNB;
        return w[IW-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] f_step(
        input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] inc, tot, base;
        inc  = ADDR_WIDTH'(1) << size;
        tot  = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
        base = a & ~(tot - ADDR_WIDTH'(1));
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && f_wrap_ok(len))
            return base + ((a + inc - base) & (tot - ADDR_WIDTH'(1)));
        return a + inc;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    wst_t                  r_wst, w_wst_nxt;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wlen, r_wcnt;
    logic [2:0]            r_wsize;
    logic [1:0]            r_wburst, r_bresp;
    logic                  r_werr, r_awready, r_wready, r_bvalid;
    logic                  w_aw_hs, w_w_hs, w_b_hs, w_wfinal;
    logic                  w_wbeat_err, w_mem_we;
    logic                  w_awready_nxt, w_wready_nxt, w_bvalid_nxt;

    assign w_aw_hs  = awvalid & r_awready;
    assign w_w_hs   = wvalid & r_wready;
    assign w_b_hs   = bready & r_bvalid;
    assign w_wfinal = (r_wcnt == r_wlen);
    assign w_wbeat_err = !f_in_range(r_waddr) | (wlast != w_wfinal);
    assign w_mem_we = w_w_hs & !areset & !f_cmd_err(r_wburst, r_wsize)
                    & f_in_range(r_waddr);

    always_comb begin
        w_wst_nxt = r_wst;
        case (r_wst)
            W_IDLE:  if (w_aw_hs) w_wst_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wfinal) w_wst_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wst_nxt = W_IDLE;
            default: w_wst_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_awready_nxt = (w_wst_nxt == W_IDLE);
        w_wready_nxt  = (w_wst_nxt == W_DATA);
        w_bvalid_nxt  = (w_wst_nxt == W_RESP);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wst     <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_wsize   <= '0;
            r_wburst  <= '0;
            r_werr    <= 1'b0;
        end else begin
            r_wst     <= w_wst_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            if (w_aw_hs) begin
                r_waddr  <= awaddr;
                r_wlen   <= awlen;
                r_wsize  <= awsize;
                r_wburst <= awburst;
                r_wcnt   <= '0;
                r_werr   <= f_cmd_err(awburst, awsize)
                          | (awburst == 2'b10 && !f_wrap_ok(awlen));
            end
            if (w_w_hs) begin
                r_waddr <= f_step(r_waddr, r_wlen, r_wsize, r_wburst);
                r_wcnt  <= r_wcnt + 8'd1;
                r_werr  <= r_werr | w_wbeat_err;
                if (w_wfinal)
                    r_bresp <= (r_werr | w_wbeat_err) ? 2'b10 : 2'b00;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_mem_we)
            for (int b = 0; b < NB; b++)
                if (wstrb[b])
                    r_mem[f_idx(r_waddr)][b*8 +: 8] <= wdata[b*8 +: 8];
    end

    rst_t                  r_rst, w_rst_nxt;
    logic [ADDR_WIDTH-1:0] r_raddr, w_ld_addr;
    logic [7:0]            r_rlen, r_rcnt, w_ld_len;
    logic [2:0]            r_rsize, w_ld_size;
    logic [1:0]            r_rburst, w_ld_burst, r_rresp, w_ld_resp;
    logic [DATA_WIDTH-1:0] r_rdata, w_ld_data;
    logic                  r_arready, r_rvalid, r_rlast;
    logic                  w_ar_hs, w_r_hs, w_rfinal, w_ld, w_ld_bad, w_ld_last;
    logic                  w_arready_nxt, w_rvalid_nxt;

    assign w_ar_hs  = arvalid & r_arready;
    assign w_r_hs   = rready & r_rvalid;
    assign w_rfinal = (r_rcnt == r_rlen);

    always_comb begin
        w_rst_nxt = r_rst;
        case (r_rst)
            R_IDLE:  if (w_ar_hs) w_rst_nxt = R_DATA;
            R_DATA:  if (w_r_hs && w_rfinal) w_rst_nxt = R_IDLE;
            default: w_rst_nxt = R_IDLE;
        endcase
    end

    // Beat loaded on this edge: beat 0 straight from AR, else the next beat.
    always_comb begin
        w_arready_nxt = (w_rst_nxt == R_IDLE);
        w_rvalid_nxt  = (w_rst_nxt == R_DATA);
        w_ld       = w_ar_hs | (w_r_hs & !w_rfinal);
        w_ld_len   = w_ar_hs ? arlen   : r_rlen;
        w_ld_size  = w_ar_hs ? arsize  : r_rsize;
        w_ld_burst = w_ar_hs ? arburst : r_rburst;
        w_ld_addr  = w_ar_hs ? araddr
                   : f_step(r_raddr, r_rlen, r_rsize, r_rburst);
        w_ld_last  = w_ar_hs ? (arlen == 8'd0) : (r_rcnt + 8'd1 == r_rlen);
        w_ld_bad   = f_cmd_err(w_ld_burst, w_ld_size) | !f_in_range(w_ld_addr);
        w_ld_data  = w_ld_bad ? '0 : r_mem[f_idx(w_ld_addr)];
        w_ld_resp  = (w_ld_bad | (w_ld_burst == 2'b10 && !f_wrap_ok(w_ld_len)))
                   ? 2'b10 : 2'b00;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rst     <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rsize   <= '0;
            r_rburst  <= '0;
        end else begin
            r_rst     <= w_rst_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            if (w_ar_hs) begin
                r_raddr  <= araddr;
                r_rlen   <= arlen;
                r_rsize  <= arsize;
                r_rburst <= arburst;
                r_rcnt   <= '0;
            end else if (w_r_hs && !w_rfinal) begin
                r_raddr <= w_ld_addr;
                r_rcnt  <= r_rcnt + 8'd1;
            end
            if (w_ld) begin
                r_rdata <= w_ld_data;
                r_rresp <= w_ld_resp;
                r_rlast <= w_ld_last;
            end else if (w_r_hs) begin
                r_rlast <= 1'b0;
            end
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;

endmodule
